// File: rtl/awb_gain_stat_pkg.sv
// Shared definitions for the gray-world AWB statistics stage and the
// downstream multiply/divide stage that decodes skip_index.
package awb_gain_stat_pkg;

  localparam logic [15:0] GAIN_UNITY = 16'h0101;

  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;

  typedef enum logic [1:0] {
    ST_ACC,
    ST_CMP,
    ST_NORM,
    ST_OUT
  } awb_state_t;

  // Divisor bytes must never be zero.
  function automatic logic [7:0] clamp_div(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/awb_gain_stat_sat_acc.sv
// Saturating per-channel pixel accumulator. `sum` is the accumulator plus the
// pixel presented this cycle, so a frame-end snapshot can include that pixel.
module sat_acc #(
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             add_en,
  input  logic [7:0]       add_val,
  input  logic             clr,
  output logic [ACC_W-1:0] sum
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   wide;

  assign wide = {1'b0, acc} + {{(ACC_W-7){1'b0}}, add_val};

  always_comb begin
    sum = acc;
    if (add_en) begin
      sum = wide[ACC_W] ? '1 : wide[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/awb_gain_stat.sv
// Gray-world white-balance statistics: per-frame channel sums, reference
// channel selection, 8-bit normalisation and gain ratio output.
module awb_gain_stat
  import awb_gain_stat_pkg::*;
#(
  parameter int unsigned ACC_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        src_valid,
  input  logic [23:0] src_data,
  input  logic        frame_end,
  output logic        gain_valid,
  output logic [1:0]  skip_index,
  output logic [15:0] gain_mul,
  output logic [15:0] gain_div,
  output logic        busy
);

  awb_state_t       state, state_nx;
  logic [ACC_W-1:0] sum  [3];
  logic [ACC_W-1:0] snap [3];
  logic [ACC_W-1:0] ref_val;
  logic [1:0]       ref_idx, cmp_idx;
  logic [7:0]       lo_val, hi_val;
  logic             take_snap, norm_shift, norm_done;

  sat_acc #(.ACC_W(ACC_W)) u_acc0 (
    .clk(clk), .rst_n(rst_n), .add_en(src_valid), .add_val(src_data[7:0]),
    .clr(frame_end), .sum(sum[0])
  );
  sat_acc #(.ACC_W(ACC_W)) u_acc1 (
    .clk(clk), .rst_n(rst_n), .add_en(src_valid), .add_val(src_data[15:8]),
    .clr(frame_end), .sum(sum[1])
  );
  sat_acc #(.ACC_W(ACC_W)) u_acc2 (
    .clk(clk), .rst_n(rst_n), .add_en(src_valid), .add_val(src_data[23:16]),
    .clr(frame_end), .sum(sum[2])
  );

  assign busy      = (state != ST_ACC);
  assign take_snap = frame_end && (state == ST_ACC);

  always_comb begin
    cmp_idx = CH0;
    if (snap[1] > snap[0]) begin
      cmp_idx = CH1;
    end
    if (snap[2] > ((cmp_idx == CH1) ? snap[1] : snap[0])) begin
      cmp_idx = CH2;
    end
  end

  always_comb begin
    ref_val = snap[0];
    lo_val  = snap[1][7:0];
    hi_val  = snap[2][7:0];
    unique case (ref_idx)
      CH1: begin
        ref_val = snap[1];
        lo_val  = snap[0][7:0];
        hi_val  = snap[2][7:0];
      end
      CH2: begin
        ref_val = snap[2];
        lo_val  = snap[0][7:0];
        hi_val  = snap[1][7:0];
      end
      default: ;
    endcase
  end

  assign norm_shift = (state == ST_NORM) && (ref_val[ACC_W-1:8] != '0);
  assign norm_done  = (state == ST_NORM) && (ref_val[ACC_W-1:8] == '0);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_ACC:  if (frame_end) state_nx = ST_CMP;
      ST_CMP:  state_nx = ST_NORM;
      ST_NORM: if (norm_done) state_nx = ST_OUT;
      ST_OUT:  state_nx = ST_ACC;
      default: state_nx = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ACC;
      ref_idx <= CH0;
      for (int unsigned i = 0; i < 3; i++) snap[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_CMP) ref_idx <= cmp_idx;
      for (int unsigned i = 0; i < 3; i++) begin
        if (take_snap) snap[i] <= sum[i];
        else if (norm_shift) snap[i] <= snap[i] >> 1;
      end
    end
  end

  // Outputs load on the NORM->OUT edge so they are already visible during OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gain_valid <= 1'b0;
      skip_index <= CH0;
      gain_mul   <= GAIN_UNITY;
      gain_div   <= GAIN_UNITY;
    end else begin
      gain_valid <= norm_done;
      if (norm_done) begin
        if (ref_val[7:0] == 8'd0) begin
          skip_index <= CH0;
          gain_mul   <= GAIN_UNITY;
          gain_div   <= GAIN_UNITY;
        end else begin
          skip_index <= ref_idx;
          gain_mul   <= {ref_val[7:0], ref_val[7:0]};
          gain_div   <= {clamp_div(hi_val), clamp_div(lo_val)};
        end
      end
    end
  end

endmodule

// File: tb/tb_awb_gain_stat.sv
// Self-checking bench for awb_gain_stat: directed table, corner sequences,
// random frames against a behavioural model, and a narrow saturation build.
module tb_awb_gain_stat;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        src_valid, frame_end;
  logic [23:0] src_data;
  logic        gain_valid, busy;
  logic [1:0]  skip_index;
  logic [15:0] gain_mul, gain_div;

  logic        s_valid, s_fe;
  logic [23:0] s_data;
  logic        s_gv, s_busy;
  logic [1:0]  s_skip;
  logic [15:0] s_mul, s_div;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  awb_gain_stat #(.ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
    .frame_end(frame_end), .gain_valid(gain_valid), .skip_index(skip_index),
    .gain_mul(gain_mul), .gain_div(gain_div), .busy(busy)
  );

  awb_gain_stat #(.ACC_W(12)) dut_s (
    .clk(clk), .rst_n(rst_n), .src_valid(s_valid), .src_data(s_data),
    .frame_end(s_fe), .gain_valid(s_gv), .skip_index(s_skip),
    .gain_mul(s_mul), .gain_div(s_div), .busy(s_busy)
  );

  typedef struct {
    int unsigned s0, s1, s2;
    logic [1:0]  skip;
    logic [15:0] mul, div;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gray-world model: saturated sums, strict-max reference, halve until the
  // reference fits a byte, ratio bytes of the other two channels.
  function automatic void model(input longint unsigned a0, a1, a2, input int unsigned w,
                                output logic [1:0] sk, output logic [15:0] mul,
                                output logic [15:0] div, output int lat);
    longint unsigned s[3];
    longint unsigned lim, rv, lv, hv;
    int r, n, lo, hi;
    lim = (64'd1 << w) - 1;
    s[0] = (a0 > lim) ? lim : a0;
    s[1] = (a1 > lim) ? lim : a1;
    s[2] = (a2 > lim) ? lim : a2;
    r = 0;
    for (int k = 1; k < 3; k++) if (s[k] > s[r]) r = k;
    n = 0;
    while ((s[r] >> n) >= 256) n++;
    lat = 3 + n;
    if (s[r] == 0) begin
      sk = 2'd0; mul = 16'h0101; div = 16'h0101;
    end else begin
      lo = (r == 0) ? 1 : 0;
      hi = (r == 2) ? 1 : 2;
      rv = s[r] >> n;
      lv = s[lo] >> n;
      hv = s[hi] >> n;
      if (lv == 0) lv = 1;
      if (hv == 0) hv = 1;
      sk  = 2'(r);
      mul = {rv[7:0], rv[7:0]};
      div = {hv[7:0], lv[7:0]};
    end
  endfunction

  task automatic drive_frame(input int unsigned s0, s1, s2);
    int unsigned r0, r1, r2, p0, p1, p2;
    r0 = s0; r1 = s1; r2 = s2;
    while (r0 + r1 + r2 > 0) begin
      if ($urandom_range(0, 3) == 0) begin
        src_valid = 1'b0;
        src_data  = 24'($urandom);
      end else begin
        p0 = (r0 > 255) ? 255 : r0;
        p1 = (r1 > 255) ? 255 : r1;
        p2 = (r2 > 255) ? 255 : r2;
        src_valid = 1'b1;
        src_data  = {p2[7:0], p1[7:0], p0[7:0]};
        r0 -= p0; r1 -= p1; r2 -= p2;
      end
      tick();
    end
    src_valid = 1'b0;
  endtask

  task automatic await_gain(input int start, output int lat);
    lat = -1;
    for (int j = start; j <= start + 80; j++) begin
      if (gain_valid) begin
        lat = j;
        break;
      end
      tick();
    end
  endtask

  task automatic check_result(input string name, input int lat, input vec_t v);
    check({name, " latency"}, lat, v.lat);
    check({name, " skip_index"}, skip_index, v.skip);
    check({name, " gain_mul"}, gain_mul, v.mul);
    check({name, " gain_div"}, gain_div, v.div);
    tick();
    check({name, " pulse width"}, gain_valid, 1'b0);
    check({name, " busy after"}, busy, 1'b0);
  endtask

  task automatic frame_check(input string name, input vec_t v);
    int lat;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check({name, " busy T+1"}, busy, 1'b1);
    await_gain(1, lat);
    check_result(name, lat, v);
  endtask

  initial begin
    vec_t tbl[5];
    vec_t v;
    int lat, pulses;
    longint unsigned m0, m1, m2;

    tbl[0] = '{s0: 1000, s1: 2000, s2: 4000, skip: 2'd2, mul: 16'hFAFA, div: 16'h7D3E, lat: 7};
    tbl[1] = '{s0: 0,    s1: 0,    s2: 0,    skip: 2'd0, mul: 16'h0101, div: 16'h0101, lat: 3};
    tbl[2] = '{s0: 200,  s1: 200,  s2: 100,  skip: 2'd0, mul: 16'hC8C8, div: 16'h64C8, lat: 3};
    tbl[3] = '{s0: 0,    s1: 5000, s2: 10,   skip: 2'd1, mul: 16'h9C9C, div: 16'h0101, lat: 8};
    tbl[4] = '{s0: 300,  s1: 600,  s2: 900,  skip: 2'd2, mul: 16'hE1E1, div: 16'h964B, lat: 5};

    rst_n = 1'b0; src_valid = 1'b0; src_data = '0; frame_end = 1'b0;
    s_valid = 1'b0; s_data = '0; s_fe = 1'b0;
    repeat (3) tick();
    check("reset gain_valid", gain_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset skip_index", skip_index, 2'd0);
    check("reset gain_mul", gain_mul, 16'h0101);
    check("reset gain_div", gain_div, 16'h0101);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      drive_frame(tbl[i].s0, tbl[i].s1, tbl[i].s2);
      frame_check($sformatf("table[%0d]", i), tbl[i]);
      repeat (30) tick();
    end

    // Pixel in the frame_end cycle belongs to the ending frame; T+1 to the next.
    drive_frame(100, 50, 0);
    frame_end = 1'b1; src_valid = 1'b1; src_data = {8'd200, 8'd0, 8'd0};
    tick();
    frame_end = 1'b0; src_valid = 1'b1; src_data = {8'd0, 8'd77, 8'd0};
    check("boundary busy T+1", busy, 1'b1);
    tick();
    src_valid = 1'b0;
    await_gain(2, lat);
    v = '{s0: 0, s1: 0, s2: 0, skip: 2'd2, mul: 16'hC8C8, div: 16'h3264, lat: 3};
    check_result("boundary", lat, v);
    repeat (30) tick();
    v = '{s0: 0, s1: 0, s2: 0, skip: 2'd1, mul: 16'h4D4D, div: 16'h0101, lat: 3};
    frame_check("boundary next", v);
    repeat (30) tick();

    // Second frame_end while busy: first result survives, second is dropped.
    drive_frame(1000, 2000, 4000);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0; src_valid = 1'b1; src_data = {8'd250, 8'd0, 8'd0};
    tick();
    src_valid = 1'b0; frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    await_gain(3, lat);
    v = '{s0: 0, s1: 0, s2: 0, skip: 2'd2, mul: 16'hFAFA, div: 16'h7D3E, lat: 7};
    check_result("overrun", lat, v);
    pulses = 0;
    for (int j = 0; j < 40; j++) begin
      if (gain_valid) pulses++;
      tick();
    end
    check("overrun dropped pulses", pulses, 0);
    drive_frame(30, 20, 10);
    v = '{s0: 0, s1: 0, s2: 0, skip: 2'd0, mul: 16'h1E1E, div: 16'h0A14, lat: 3};
    frame_check("overrun restart", v);
    repeat (30) tick();

    // Reset while normalising.
    drive_frame(1000, 2000, 4000);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midreset gain_mul", gain_mul, 16'h0101);
    check("midreset gain_div", gain_div, 16'h0101);
    check("midreset skip_index", skip_index, 2'd0);
    check("midreset busy", busy, 1'b0);
    check("midreset gain_valid", gain_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int j = 0; j < 20; j++) begin
      if (gain_valid) pulses++;
      tick();
    end
    check("midreset no pulse", pulses, 0);

    // Random frames against the model.
    for (int f = 0; f < 10; f++) begin
      int unsigned npix;
      npix = $urandom_range(1, 300);
      m0 = 0; m1 = 0; m2 = 0;
      for (int unsigned p = 0; p < npix; p++) begin
        src_valid = ($urandom_range(0, 3) != 0);
        src_data  = 24'($urandom);
        if (f % 3 == 1) src_data[15:8] = 8'd0;
        if (src_valid) begin
          m0 += src_data[7:0];
          m1 += src_data[15:8];
          m2 += src_data[23:16];
        end
        tick();
      end
      src_valid = 1'b0;
      model(m0, m1, m2, 32, v.skip, v.mul, v.div, v.lat);
      frame_check($sformatf("random[%0d]", f), v);
      repeat (30) tick();
    end

    // Narrow build: 20 x 255 overflows a 12-bit accumulator.
    s_valid = 1'b1;
    s_data  = {8'd0, 8'd200, 8'd255};
    repeat (20) tick();
    s_valid = 1'b0;
    check("sat acc0 all-ones", dut_s.u_acc0.acc, 32'hFFF);
    s_fe = 1'b1;
    tick();
    s_fe = 1'b0;
    lat = -1;
    for (int j = 1; j <= 60; j++) begin
      if (s_gv) begin
        lat = j;
        break;
      end
      tick();
    end
    model(64'd5100, 64'd4000, 64'd0, 12, v.skip, v.mul, v.div, v.lat);
    check("sat latency", lat, v.lat);
    check("sat skip_index", s_skip, v.skip);
    check("sat gain_mul", s_mul, v.mul);
    check("sat gain_div", s_div, v.div);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
